// File: rtl/sram_unpack_buffer.sv
// rtl/sram_unpack_buffer.sv - SRAM word stream unpacked into image/weight element buffers
// Fills the image region then the weight region from a req/valid stream; registered random-access reads.
module sram_unpack_buffer #(
  parameter  int WORD_W    = 32,
  parameter  int ELEM_W    = 16,
  parameter  int IMG_DEPTH = 64,
  parameter  int WGT_DEPTH = 1024,
  localparam int IMG_AW    = $clog2(IMG_DEPTH),
  localparam int WGT_AW    = $clog2(WGT_DEPTH)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_load,
  input  logic [1:0]        load_mode,
  input  logic [WORD_W-1:0] sram_rdata,
  input  logic              sram_rvalid,
  output logic              sram_req,
  output logic              load_busy,
  output logic              load_done,
  output logic              img_valid,
  output logic              wgt_valid,
  input  logic [IMG_AW-1:0] img_raddr,
  output logic [ELEM_W-1:0] img_rdata,
  input  logic [WGT_AW-1:0] wgt_raddr,
  output logic [ELEM_W-1:0] wgt_rdata
);

  localparam int EPW       = WORD_W / ELEM_W;
  localparam int IMG_WORDS = IMG_DEPTH / EPW;
  localparam int WGT_WORDS = WGT_DEPTH / EPW;
  localparam int MAX_WORDS = (IMG_WORDS > WGT_WORDS) ? IMG_WORDS : WGT_WORDS;
  localparam int CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_IMG, S_LOAD_WGT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               img_valid_q, img_valid_d;
  logic               wgt_valid_q, wgt_valid_d;
  logic               wgt_next_q, wgt_next_d;
  logic               img_we, wgt_we;
  logic               img_last, wgt_last;
  logic [IMG_AW-1:0]  img_base;
  logic [WGT_AW-1:0]  wgt_base;
  logic [ELEM_W-1:0]  img_rdata_q, wgt_rdata_q;

  logic [ELEM_W-1:0]  img_mem [IMG_DEPTH];
  logic [ELEM_W-1:0]  wgt_mem [WGT_DEPTH];

  assign img_last = (cnt_q == CNT_W'(IMG_WORDS - 1));
  assign wgt_last = (cnt_q == CNT_W'(WGT_WORDS - 1));
  assign img_base = IMG_AW'(cnt_q * EPW);
  assign wgt_base = WGT_AW'(cnt_q * EPW);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    img_valid_d = img_valid_q;
    wgt_valid_d = wgt_valid_q;
    wgt_next_d  = wgt_next_q;
    sram_req    = 1'b0;
    load_busy   = 1'b0;
    load_done   = 1'b0;
    img_we      = 1'b0;
    wgt_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_load) begin
          cnt_d = '0;
          if (load_mode == 2'b10) begin
            state_d     = S_LOAD_WGT;
            wgt_valid_d = 1'b0;
            wgt_next_d  = 1'b0;
          end else begin
            state_d     = S_LOAD_IMG;
            img_valid_d = 1'b0;
            wgt_next_d  = (load_mode != 2'b01);
          end
        end
      end
      S_LOAD_IMG: begin
        sram_req  = 1'b1;
        load_busy = 1'b1;
        if (sram_rvalid) begin
          img_we = 1'b1;
          if (img_last) begin
            img_valid_d = 1'b1;
            cnt_d       = '0;
            if (wgt_next_q) begin
              state_d     = S_LOAD_WGT;
              wgt_valid_d = 1'b0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_LOAD_WGT: begin
        sram_req  = 1'b1;
        load_busy = 1'b1;
        if (sram_rvalid) begin
          wgt_we = 1'b1;
          if (wgt_last) begin
            wgt_valid_d = 1'b1;
            cnt_d       = '0;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        load_done = 1'b1;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Read data is gated by the flag as it stood before this edge's possible write.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      img_valid_q <= 1'b0;
      wgt_valid_q <= 1'b0;
      wgt_next_q  <= 1'b0;
      img_rdata_q <= '0;
      wgt_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      img_valid_q <= img_valid_d;
      wgt_valid_q <= wgt_valid_d;
      wgt_next_q  <= wgt_next_d;
      img_rdata_q <= img_valid_q ? img_mem[img_raddr] : '0;
      wgt_rdata_q <= wgt_valid_q ? wgt_mem[wgt_raddr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < EPW; k++) begin
      if (img_we) img_mem[img_base + IMG_AW'(k)] <= sram_rdata[k*ELEM_W +: ELEM_W];
      if (wgt_we) wgt_mem[wgt_base + WGT_AW'(k)] <= sram_rdata[k*ELEM_W +: ELEM_W];
    end
  end

  assign img_valid = img_valid_q;
  assign wgt_valid = wgt_valid_q;
  assign img_rdata = img_rdata_q;
  assign wgt_rdata = wgt_rdata_q;

endmodule

// File: tb/tb_sram_unpack_buffer.sv
// tb/tb_sram_unpack_buffer.sv - self-checking bench for sram_unpack_buffer
// Reference keeps the expected region contents and valid flags as plain arrays and bits.
module tb_sram_unpack_buffer;

  localparam int IMG_DEPTH = 64;
  localparam int WGT_DEPTH = 1024;
  localparam int IMG_WORDS = 32;
  localparam int WGT_WORDS = 512;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start_load;
  logic [1:0]  load_mode;
  logic [31:0] sram_rdata;
  logic        sram_rvalid;
  logic        sram_req, load_busy, load_done, img_valid, wgt_valid;
  logic [5:0]  img_raddr;
  logic [15:0] img_rdata;
  logic [9:0]  wgt_raddr;
  logic [15:0] wgt_rdata;

  logic        b_start;
  logic [1:0]  b_mode;
  logic [63:0] b_rdata;
  logic        b_rvalid;
  logic        b_req, b_busy, b_done, b_imgv, b_wgtv;
  logic [3:0]  b_img_raddr, b_wgt_raddr;
  logic [7:0]  b_img_rdata, b_wgt_rdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_img [IMG_DEPTH];
  logic [15:0] exp_wgt [WGT_DEPTH];
  logic        exp_img_v, exp_wgt_v;

  always #5 clk = ~clk;

  sram_unpack_buffer dut (
    .clk(clk), .n_rst(n_rst), .start_load(start_load), .load_mode(load_mode),
    .sram_rdata(sram_rdata), .sram_rvalid(sram_rvalid), .sram_req(sram_req),
    .load_busy(load_busy), .load_done(load_done), .img_valid(img_valid),
    .wgt_valid(wgt_valid), .img_raddr(img_raddr), .img_rdata(img_rdata),
    .wgt_raddr(wgt_raddr), .wgt_rdata(wgt_rdata)
  );

  sram_unpack_buffer #(.WORD_W(64), .ELEM_W(8), .IMG_DEPTH(16), .WGT_DEPTH(16)) dut_b (
    .clk(clk), .n_rst(n_rst), .start_load(b_start), .load_mode(b_mode),
    .sram_rdata(b_rdata), .sram_rvalid(b_rvalid), .sram_req(b_req),
    .load_busy(b_busy), .load_done(b_done), .img_valid(b_imgv),
    .wgt_valid(b_wgtv), .img_raddr(b_img_raddr), .img_rdata(b_img_rdata),
    .wgt_raddr(b_wgt_raddr), .wgt_rdata(b_wgt_rdata)
  );

  function automatic logic [31:0] gen_word(input int kind, input int n);
    if (kind == 0) return {16'(2*n + 1), 16'(2*n)};
    if (kind == 1) return 32'hA5A5_A5A5;
    return $urandom;
  endfunction

  task automatic check_flags(input string tag);
    n_cmp++;
    if (img_valid !== exp_img_v || wgt_valid !== exp_wgt_v) begin
      n_err++;
      $display("FAIL %s: img_valid=%b wgt_valid=%b expected %b %b", tag, img_valid, wgt_valid, exp_img_v, exp_wgt_v);
    end
  endtask

  task automatic read_pair(input int ia, input int wa, output logic [15:0] ri, output logic [15:0] rw);
    img_raddr = 6'(ia);
    wgt_raddr = 10'(wa);
    @(negedge clk);
    ri = img_rdata;
    rw = wgt_rdata;
  endtask

  task automatic check_reads(input int n);
    logic [15:0] ri, rw, ei, ew;
    for (int i = 0; i < n; i++) begin
      int ia, wa;
      ia = $urandom_range(0, IMG_DEPTH - 1);
      wa = $urandom_range(0, WGT_DEPTH - 1);
      ei = exp_img_v ? exp_img[ia] : 16'h0;
      ew = exp_wgt_v ? exp_wgt[wa] : 16'h0;
      read_pair(ia, wa, ri, rw);
      n_cmp++;
      if (ri !== ei || rw !== ew) begin
        n_err++;
        $display("FAIL read img[%0d]=%h wgt[%0d]=%h expected %h %h", ia, ri, wa, rw, ei, ew);
      end
    end
  endtask

  // Streams one load; stop_wgt >= 0 returns right after that many weight words.
  task automatic run_load(input logic [1:0] mode, input int kind, input int duty, input int stop_wgt);
    int iw, ww, total, acc, cyc, ia, wa, n;
    logic [15:0] ei, ew;
    logic        rv;
    logic [31:0] w;
    iw = (mode == 2'b10) ? 0 : IMG_WORDS;
    ww = (mode == 2'b01) ? 0 : WGT_WORDS;
    total = iw + ww;
    @(negedge clk);
    start_load = 1'b1;
    load_mode  = mode;
    @(negedge clk);
    start_load = 1'b0;
    load_mode  = 2'($urandom);
    if (iw > 0) exp_img_v = 1'b0;
    else        exp_wgt_v = 1'b0;
    acc = 0;
    cyc = 0;
    while (acc < total) begin
      n_cmp++;
      if (sram_req !== 1'b1 || load_busy !== 1'b1 || load_done !== 1'b0) begin
        n_err++;
        $display("FAIL load_hs at word %0d: req=%b busy=%b done=%b expected 1 1 0", acc, sram_req, load_busy, load_done);
      end
      check_flags("load_flags");
      ia = $urandom_range(0, IMG_DEPTH - 1);
      wa = $urandom_range(0, WGT_DEPTH - 1);
      img_raddr = 6'(ia);
      wgt_raddr = 10'(wa);
      ei = exp_img_v ? exp_img[ia] : 16'h0;
      ew = exp_wgt_v ? exp_wgt[wa] : 16'h0;
      rv = ($urandom % 100) < duty;
      n  = (acc < iw) ? acc : acc - iw;
      w  = gen_word(kind, n);
      sram_rvalid = rv;
      sram_rdata  = w;
      start_load  = ($urandom % 8) == 0;
      @(negedge clk);
      n_cmp++;
      if (img_rdata !== ei || wgt_rdata !== ew) begin
        n_err++;
        $display("FAIL load_read img[%0d]=%h wgt[%0d]=%h expected %h %h", ia, img_rdata, wa, wgt_rdata, ei, ew);
      end
      if (rv) begin
        for (int k = 0; k < 2; k++) begin
          if (acc < iw) exp_img[n*2 + k] = w[16*k +: 16];
          else          exp_wgt[n*2 + k] = w[16*k +: 16];
        end
        acc++;
        if (iw > 0 && acc == iw) begin
          exp_img_v = 1'b1;
          if (ww > 0) exp_wgt_v = 1'b0;
        end
        if (ww > 0 && acc == total) exp_wgt_v = 1'b1;
        if (stop_wgt >= 0 && acc > iw && acc - iw == stop_wgt) begin
          sram_rvalid = 1'b0;
          start_load  = 1'b0;
          return;
        end
      end
      cyc++;
      if (cyc > 20000) begin
        n_cmp++;
        n_err++;
        $display("FAIL load_timeout accepted=%0d expected %0d", acc, total);
        break;
      end
    end
    sram_rvalid = 1'b0;
    start_load  = 1'b0;
    n_cmp++;
    if (load_done !== 1'b1 || load_busy !== 1'b0 || sram_req !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: done=%b busy=%b req=%b expected 1 0 0", load_done, load_busy, sram_req);
    end
    check_flags("done_flags");
    @(negedge clk);
    n_cmp++;
    if (load_done !== 1'b0 || load_busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_single: done=%b busy=%b expected 0 0", load_done, load_busy);
    end
  endtask

  task automatic test_reset;
    logic [15:0] ri, rw;
    n_rst = 1'b0;
    start_load = 1'b0; load_mode = 2'b00; sram_rdata = '0; sram_rvalid = 1'b0;
    img_raddr = 6'd5; wgt_raddr = '0;
    b_start = 1'b0; b_mode = 2'b00; b_rdata = '0; b_rvalid = 1'b0;
    b_img_raddr = '0; b_wgt_raddr = '0;
    exp_img_v = 1'b0; exp_wgt_v = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sram_req, load_busy, load_done, img_valid, wgt_valid} !== 5'b0 || img_rdata !== 16'h0 || wgt_rdata !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: req=%b busy=%b done=%b iv=%b wv=%b ir=%h wr=%h expected all 0",
               sram_req, load_busy, load_done, img_valid, wgt_valid, img_rdata, wgt_rdata);
    end
    n_rst = 1'b1;
    read_pair(5, 0, ri, rw);
    n_cmp++;
    if (ri !== 16'h0) begin
      n_err++;
      $display("FAIL reset_read img[5]=%h expected 0000", ri);
    end
  endtask

  task automatic test_mode00;
    logic [15:0] ri, rw;
    run_load(2'b00, 0, 100, -1);
    read_pair(7, 1023, ri, rw);
    n_cmp++;
    if (ri !== 16'h0007 || rw !== 16'h03FF) begin
      n_err++;
      $display("FAIL mode00_points img[7]=%h wgt[1023]=%h expected 0007 03ff", ri, rw);
    end
    check_reads(20);
  endtask

  task automatic test_mode10;
    logic [15:0] ri, rw;
    run_load(2'b10, 1, 90, -1);
    read_pair(7, 0, ri, rw);
    n_cmp++;
    if (ri !== 16'h0007 || rw !== 16'hA5A5 || img_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mode10_points img[7]=%h wgt[0]=%h iv=%b expected 0007 a5a5 1", ri, rw, img_valid);
    end
    check_reads(20);
  endtask

  task automatic test_gaps_mode01;
    run_load(2'b01, 2, 50, -1);
    for (int i = 0; i < 6; i++) begin
      sram_rvalid = 1'b1;
      sram_rdata  = $urandom;
      @(negedge clk);
      n_cmp++;
      if (sram_req !== 1'b0 || load_busy !== 1'b0) begin
        n_err++;
        $display("FAIL idle_req: req=%b busy=%b expected 0 0", sram_req, load_busy);
      end
    end
    sram_rvalid = 1'b0;
    check_reads(30);
  endtask

  task automatic test_reset_midload;
    run_load(2'b00, 2, 70, 100);
    n_rst = 1'b0;
    #1;
    exp_img_v = 1'b0;
    exp_wgt_v = 1'b0;
    n_cmp++;
    if ({sram_req, load_busy, load_done, img_valid, wgt_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL midload_reset: req=%b busy=%b done=%b iv=%b wv=%b expected all 0",
               sram_req, load_busy, load_done, img_valid, wgt_valid);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (load_done !== 1'b0 || load_busy !== 1'b0) begin
        n_err++;
        $display("FAIL midload_nodone: done=%b busy=%b expected 0 0", load_done, load_busy);
      end
    end
    run_load(2'b00, 2, 80, -1);
    check_reads(30);
  endtask

  task automatic test_wide_params;
    logic [63:0] w1;
    logic [7:0]  e;
    w1 = {$urandom, $urandom};
    @(negedge clk);
    b_start = 1'b1;
    b_mode  = 2'b01;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (b_req !== 1'b1 || b_done !== 1'b0) begin
        n_err++;
        $display("FAIL wide_req word %0d: req=%b done=%b expected 1 0", i, b_req, b_done);
      end
      b_rvalid = 1'b1;
      b_rdata  = (i == 0) ? 64'h0706050403020100 : w1;
      @(negedge clk);
    end
    b_rvalid = 1'b0;
    n_cmp++;
    if (b_done !== 1'b1 || b_imgv !== 1'b1 || b_busy !== 1'b0) begin
      n_err++;
      $display("FAIL wide_done: done=%b imgv=%b busy=%b expected 1 1 0", b_done, b_imgv, b_busy);
    end
    for (int k = 0; k < 16; k++) begin
      b_img_raddr = 4'(k);
      e = (k < 8) ? 8'(k) : w1[8*(k-8) +: 8];
      @(negedge clk);
      n_cmp++;
      if (b_img_rdata !== e) begin
        n_err++;
        $display("FAIL wide_read img[%0d]=%h expected %h", k, b_img_rdata, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_mode10();
    test_gaps_mode01();
    test_reset_midload();
    test_wide_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
